// File: rtl/fifo_pkg.sv
// Shared types and helpers for the multi-channel round-robin FIFO (fifo_rr_mc).
// Optional macro: FIFO_RR_MC_ALMOST_FULL_EN (no package content depends on it).
package fifo_pkg;

   // Upper bounds for the per-channel state fields; DEPTH must not exceed 2**PTR_MAX_W.
   localparam int unsigned PTR_MAX_W = 16;
   localparam int unsigned CNT_MAX_W = PTR_MAX_W + 1;

   typedef struct packed {
      logic [PTR_MAX_W-1:0] wr_ptr;
      logic [PTR_MAX_W-1:0] rd_ptr;
      logic [CNT_MAX_W-1:0] count;
   } chan_state_t;

   function automatic int unsigned width_of(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Modulo-n increment with an explicit wrap, valid for any n >= 1.
   function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
      return (v >= n - 1) ? 32'd0 : v + 32'd1;
   endfunction

endpackage

// File: rtl/fifo_chan.sv
// Single-channel FIFO: storage, wrapping pointers, occupancy and flags.
// Optional macro: FIFO_RR_MC_ALMOST_FULL_EN adds almost_full_o.
module fifo_chan
   import fifo_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 16,
`ifdef FIFO_RR_MC_ALMOST_FULL_EN
   parameter int AF_THRESH = DEPTH - 2,
`endif
   parameter int L2D = width_of(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push_req_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             push_ack_o,
   input  logic             pop_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [L2D-1:0]   count_o
`ifdef FIFO_RR_MC_ALMOST_FULL_EN
   ,output logic            almost_full_o
`endif
);

   chan_state_t      st_q, st_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_hsk;

   assign full_o     = (st_q.count == CNT_MAX_W'(DEPTH));
   assign empty_o    = (st_q.count == '0);
   assign count_o    = L2D'(st_q.count);
   assign push_ack_o = !full_o;
   assign push_hsk   = push_req_i && push_ack_o;

`ifdef FIFO_RR_MC_ALMOST_FULL_EN
   assign almost_full_o = (st_q.count >= CNT_MAX_W'(AF_THRESH));
`endif

   always_comb begin
      st_d = st_q;
      if (push_hsk) st_d.wr_ptr = PTR_MAX_W'(wrap_inc(32'(st_q.wr_ptr), DEPTH));
      if (pop_en_i) st_d.rd_ptr = PTR_MAX_W'(wrap_inc(32'(st_q.rd_ptr), DEPTH));
      if (push_hsk && !pop_en_i)      st_d.count = st_q.count + CNT_MAX_W'(1);
      else if (!push_hsk && pop_en_i) st_d.count = st_q.count - CNT_MAX_W'(1);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) st_q <= '0;
      else         st_q <= st_d;
   end

   // NOTE: storage has no reset; empty/full come from the counter, so stale data is never observed.
   always_ff @(posedge clk) begin
      for (int k = 0; k < DEPTH; k++) begin
         if (push_hsk && st_q.wr_ptr == PTR_MAX_W'(k)) mem_q[k] <= data_i;
      end
   end

   always_comb begin
      rd_data_o = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (st_q.rd_ptr == PTR_MAX_W'(k)) rd_data_o = mem_q[k];
      end
   end

endmodule

// File: rtl/fifo_rr_mc.sv
// NCH req/ack FIFOs sharing one pop port with round-robin channel selection.
// Optional macro: FIFO_RR_MC_ALMOST_FULL_EN adds the per-channel almost_full output.
module fifo_rr_mc
   import fifo_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 16,
   parameter int NCH   = 4,
`ifdef FIFO_RR_MC_ALMOST_FULL_EN
   parameter int AF_THRESH = DEPTH - 2,
`endif
   localparam int CW  = $clog2(NCH),
   localparam int L2D = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [NCH-1:0]       push_req,
   input  logic [NCH*WIDTH-1:0] data_in,
   output logic [NCH-1:0]       push_ack,
   input  logic                 pop_req,
   output logic                 pop_ack,
   output logic [WIDTH-1:0]     data_out,
   output logic [CW-1:0]        pop_chan,
   output logic [NCH-1:0]       full,
   output logic [NCH-1:0]       empty,
   output logic [NCH*L2D-1:0]   count
`ifdef FIFO_RR_MC_ALMOST_FULL_EN
   ,output logic [NCH-1:0]      almost_full
`endif
);

   logic [CW-1:0]    rr_q, rr_d;
   logic [CW-1:0]    sel, hi_sel, lo_sel;
   logic             hi_found;
   logic             pop_hsk;
   logic [NCH-1:0]   pop_en;
   logic [WIDTH-1:0] chan_rd [NCH];

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      assign pop_en[i] = pop_hsk && (sel == CW'(i));

      fifo_chan #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH),
`ifdef FIFO_RR_MC_ALMOST_FULL_EN
         .AF_THRESH (AF_THRESH),
`endif
         .L2D   (L2D)
      ) u_chan (
         .clk        (clk),
         .resetn     (resetn),
         .push_req_i (push_req[i]),
         .data_i     (data_in[i*WIDTH +: WIDTH]),
         .push_ack_o (push_ack[i]),
         .pop_en_i   (pop_en[i]),
         .rd_data_o  (chan_rd[i]),
         .full_o     (full[i]),
         .empty_o    (empty[i]),
         .count_o    (count[i*L2D +: L2D])
`ifdef FIFO_RR_MC_ALMOST_FULL_EN
         ,.almost_full_o (almost_full[i])
`endif
      );
   end

   // Lowest non-empty channel at or above rr_q wins; otherwise wrap to the lowest non-empty one.
   always_comb begin
      hi_found = 1'b0;
      hi_sel   = '0;
      lo_sel   = '0;
      for (int j = NCH - 1; j >= 0; j--) begin
         if (!empty[j]) begin
            if (CW'(j) >= rr_q) begin
               hi_found = 1'b1;
               hi_sel   = CW'(j);
            end
            lo_sel = CW'(j);
         end
      end
      sel = hi_found ? hi_sel : lo_sel;
   end

   assign pop_ack  = |(~empty);
   assign pop_hsk  = pop_req && pop_ack;
   assign data_out = pop_ack ? chan_rd[sel] : '0;
   assign pop_chan = pop_ack ? sel : '0;
   assign rr_d     = pop_hsk ? CW'(wrap_inc(32'(sel), NCH)) : rr_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rr_q <= '0;
      else         rr_q <= rr_d;
   end

endmodule

// File: tb/tb_fifo_rr_mc.sv
// Directed self-checking bench for fifo_rr_mc with DEPTH=5, NCH=4, WIDTH=4.
// Build with FIFO_RR_MC_ALMOST_FULL_EN to also exercise almost_full.
module tb_fifo_rr_mc;

   localparam int WIDTH = 4;
   localparam int DEPTH = 5;
   localparam int NCH   = 4;
   localparam int CW    = 2;
   localparam int L2D   = 3;

   logic                 clk = 1'b0;
   logic                 resetn;
   logic [NCH-1:0]       push_req;
   logic [NCH*WIDTH-1:0] data_in;
   logic [NCH-1:0]       push_ack;
   logic                 pop_req;
   logic                 pop_ack;
   logic [WIDTH-1:0]     data_out;
   logic [CW-1:0]        pop_chan;
   logic [NCH-1:0]       full;
   logic [NCH-1:0]       empty;
   logic [NCH*L2D-1:0]   count;
`ifdef FIFO_RR_MC_ALMOST_FULL_EN
   logic [NCH-1:0]       almost_full;
`endif

   int checks   = 0;
   int failures = 0;

   fifo_rr_mc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(NCH)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .push_req (push_req),
      .data_in  (data_in),
      .push_ack (push_ack),
      .pop_req  (pop_req),
      .pop_ack  (pop_ack),
      .data_out (data_out),
      .pop_chan (pop_chan),
      .full     (full),
      .empty    (empty),
      .count    (count)
`ifdef FIFO_RR_MC_ALMOST_FULL_EN
      ,.almost_full (almost_full)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [L2D-1:0] cnt(input int ch);
      return count[ch*L2D +: L2D];
   endfunction

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_empty"},    32'(empty),    32'hF);
      check({tag, "_full"},     32'(full),     32'h0);
      check({tag, "_pop_ack"},  32'(pop_ack),  32'h0);
      check({tag, "_push_ack"}, 32'(push_ack), 32'hF);
      check({tag, "_count"},    32'(count),    32'h0);
      check({tag, "_pop_chan"}, 32'(pop_chan), 32'h0);
      check({tag, "_data_out"}, 32'(data_out), 32'h0);
   endtask

   // Two cycles of pushes on every channel; channel i receives i*4+r in round r.
   task automatic preload_all();
      for (int r = 0; r < 2; r++) begin
         push_req = 4'hF;
         data_in  = {4'(12 + r), 4'(8 + r), 4'(4 + r), 4'(r)};
         step();
      end
      push_req = '0;
   endtask

   initial begin
      resetn   = 1'b0;
      push_req = '0;
      data_in  = '0;
      pop_req  = 1'b0;
      step();
      step();
      check_reset_state("rst");
      resetn = 1'b1;
      step();

      // Fill channel 2 to DEPTH with 1..5.
      for (int v = 1; v <= DEPTH; v++) begin
         push_req = 4'b0100;
         data_in  = 16'(v << 8);
         step();
      end
      push_req = '0;
      check("fill_full2",     32'(full[2]),     32'h1);
      check("fill_push_ack2", 32'(push_ack[2]), 32'h0);
      check("fill_count2",    32'(cnt(2)),      32'd5);
      check("fill_empty",     32'(empty),       32'b1011);
      check("fill_pop_chan",  32'(pop_chan),    32'd2);
      check("fill_head",      32'(data_out),    32'h1);

      // Sixth push must be refused.
      push_req = 4'b0100;
      data_in  = 16'h0600;
      check("over_push_ack2", 32'(push_ack[2]), 32'h0);
      step();
      push_req = '0;
      check("over_count2", 32'(cnt(2)), 32'd5);

      pop_req = 1'b1;
      for (int v = 1; v <= DEPTH; v++) begin
         check($sformatf("drain2_chan_%0d", v), 32'(pop_chan), 32'd2);
         check($sformatf("drain2_data_%0d", v), 32'(data_out), 32'(v));
         step();
      end
      pop_req = 1'b0;
      check("drain2_empty",    32'(empty),    32'hF);
      check("drain2_pop_ack",  32'(pop_ack),  32'h0);
      check("drain2_data_out", 32'(data_out), 32'h0);

      // Alternate push/pop on channel 0 across three pointer wraps.
      for (int n = 0; n < 3 * DEPTH; n++) begin
         push_req = 4'b0001;
         data_in  = 16'((n + 1) & 4'hF);
         step();
         push_req = '0;
         check($sformatf("wrap_count_%0d", n), 32'(cnt(0)),   32'd1);
         check($sformatf("wrap_chan_%0d", n),  32'(pop_chan), 32'd0);
         check($sformatf("wrap_data_%0d", n),  32'(data_out), 32'((n + 1) & 4'hF));
         pop_req = 1'b1;
         step();
         pop_req = 1'b0;
         check($sformatf("wrap_empty_%0d", n), 32'(cnt(0)), 32'd0);
      end

      // Reset in the middle of traffic.
      preload_all();
      pop_req = 1'b1;
      step();
      resetn = 1'b0;
      #2;
      check_reset_state("midrst_async");
      step();
      check_reset_state("midrst_cycle");
      pop_req = 1'b0;
      resetn  = 1'b1;
      step();

      // Round robin from rr_ptr = 0 with all channels loaded.
      preload_all();
      pop_req = 1'b1;
      for (int k = 0; k < 2 * NCH; k++) begin
         check($sformatf("rr_chan_%0d", k), 32'(pop_chan), 32'(k % NCH));
         check($sformatf("rr_data_%0d", k), 32'(data_out), 32'((k % NCH) * 4 + k / NCH));
         step();
      end
      pop_req = 1'b0;
      check("rr_pop_ack_after", 32'(pop_ack), 32'h0);
      check("rr_empty_after",   32'(empty),   32'hF);

      // Move rr_ptr to 2 by popping channel 1, then load channels 1 and 3 only.
      push_req = 4'b0010;
      data_in  = 16'h0050;
      step();
      push_req = '0;
      pop_req  = 1'b1;
      step();
      pop_req  = 1'b0;
      push_req = 4'b1010;
      data_in  = 16'h9070;
      step();
      push_req = 4'b1000;
      data_in  = 16'hA000;
      step();
      push_req = '0;
      check("skip_idle_chan", 32'(pop_chan), 32'd3);
      pop_req = 1'b1;
      check("skip_chan_0", 32'(pop_chan), 32'd3);
      check("skip_data_0", 32'(data_out), 32'h9);
      step();
      check("skip_chan_1", 32'(pop_chan), 32'd1);
      check("skip_data_1", 32'(data_out), 32'h7);
      step();
      check("skip_chan_2", 32'(pop_chan), 32'd3);
      check("skip_data_2", 32'(data_out), 32'hA);
      step();
      pop_req = 1'b0;
      check("skip_empty", 32'(empty), 32'hF);

      // Channel 1 full, then push and pop it in the same cycle.
      for (int v = 1; v <= DEPTH; v++) begin
         push_req = 4'b0010;
         data_in  = 16'(v << 4);
         step();
      end
      push_req = '0;
      check("fp_full1", 32'(full[1]), 32'h1);
`ifdef FIFO_RR_MC_ALMOST_FULL_EN
      check("fp_af_full", 32'(almost_full), 32'b0010);
`endif
      push_req = 4'b0010;
      data_in  = 16'h00F0;
      pop_req  = 1'b1;
      check("fp_push_ack1", 32'(push_ack[1]), 32'h0);
      check("fp_pop_chan",  32'(pop_chan),    32'd1);
      check("fp_data",      32'(data_out),    32'h1);
      step();
      push_req = '0;
      pop_req  = 1'b0;
      check("fp_count1", 32'(cnt(1)),  32'(DEPTH - 1));
      check("fp_nfull1", 32'(full[1]), 32'h0);
`ifdef FIFO_RR_MC_ALMOST_FULL_EN
      check("fp_af_after", 32'(almost_full[1]), 32'h1);
`endif
      pop_req = 1'b1;
      for (int v = 2; v <= DEPTH; v++) begin
         check($sformatf("fp_drain_%0d", v), 32'(data_out), 32'(v));
         step();
      end
      pop_req = 1'b0;
      check("fp_drain_empty", 32'(empty), 32'hF);
`ifdef FIFO_RR_MC_ALMOST_FULL_EN
      check("fp_af_empty", 32'(almost_full), 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
